// File: rtl/ram2048x8_arbiter_pkg.sv
// ram_arb_pkg: shared constants and types for the 2048x8 RAM arbiter slice.
//   ADDR_W / DATA_W / DEPTH : RAM geometry (DEPTH must equal 2**ADDR_W)
//   arb_state_t             : CLEAR (init sweep) / RUN (arbitrating)
//   req_t                   : one requester's access {we, addr, wd}
package ram_arb_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2048;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;
    } req_t;

endpackage

// File: rtl/ram2048x8_arbiter_if.sv
// ram2048x8_arbiter_if: client request/return signals plus the RAM port bundle.
//   slave  : the arbiter (drives Gnt*, RdVld*, RdData, Busy, RAM_WA/WD/WEN/RA)
//   master : clients + RAM (drive Req*, We*, Addr*, WD*, RAM_RD)
interface ram2048x8_arbiter_if;
    import ram_arb_pkg::*;

    logic              Req0, Req1;
    logic              We0, We1;
    logic [ADDR_W-1:0] Addr0, Addr1;
    logic [DATA_W-1:0] WD0, WD1;
    logic              Gnt0, Gnt1;
    logic              RdVld0, RdVld1;
    logic [DATA_W-1:0] RdData;
    logic              Busy;
    logic [ADDR_W-1:0] RAM_WA;
    logic [DATA_W-1:0] RAM_WD;
    logic              RAM_WEN;
    logic [ADDR_W-1:0] RAM_RA;
    logic [DATA_W-1:0] RAM_RD;

    modport slave (
        input  Req0, Req1, We0, We1, Addr0, Addr1, WD0, WD1, RAM_RD,
        output Gnt0, Gnt1, RdVld0, RdVld1, RdData, Busy,
               RAM_WA, RAM_WD, RAM_WEN, RAM_RA
    );

    modport master (
        output Req0, Req1, We0, We1, Addr0, Addr1, WD0, WD1, RAM_RD,
        input  Gnt0, Gnt1, RdVld0, RdVld1, RdData, Busy,
               RAM_WA, RAM_WD, RAM_WEN, RAM_RA
    );

endinterface

// File: rtl/ram2048x8_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant with a last-grant pointer.
//   Clk, Rst_n : clock, async active-low reset
//   en         : grants allowed this cycle
//   req[1:0]   : requests
//   gnt[1:0]   : combinational one-hot (or zero) grant
// ptr holds the index last granted; it resets to 1 so requester 0 wins the
// first contended cycle.
module rr_arb2 (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr;

    assign gnt[0] = en & req[0] & (~req[1] | ptr);
    assign gnt[1] = en & req[1] & (~req[0] | ~ptr);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)      ptr <= 1'b1;
        else if (gnt[1]) ptr <= 1'b1;
        else if (gnt[0]) ptr <= 1'b0;
    end

endmodule

// File: rtl/ram2048x8_arbiter.sv
// ram2048x8_arbiter: shares one 2048x8 simple dual-port RAM (1-cycle registered
// read) between two requesters, one access per cycle, round-robin.
//   Clk, Rst_n : single clock (RAM clocks tied to it), async active-low reset
//   io (slave) : Req/We/Addr/WD 0/1 in, Gnt0/1 (comb), RdVld0/1, RdData, Busy,
//                RAM_WA/RAM_WD/RAM_WEN/RAM_RA out, RAM_RD in
// Build option RAM_ARB_INIT_CLEAR_EN: after reset, sweep zeros into every
// address (Busy=1, no grants) before arbitrating. Without it, reset goes
// straight to RUN and Busy stays 0.
module ram2048x8_arbiter
    import ram_arb_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Rst_n,
    ram2048x8_arbiter_if.slave   io
);

`ifdef RAM_ARB_INIT_CLEAR_EN
    // The clear sweep starts out of reset with address 0 already on the RAM
    // port, so DEPTH writes occupy exactly DEPTH cycles.
    localparam arb_state_t RST_STATE = CLEAR;
    localparam logic       RST_BUSY  = 1'b1;
`else
    localparam arb_state_t RST_STATE = RUN;
    localparam logic       RST_BUSY  = 1'b0;
`endif

    arb_state_t        state;
    logic              busy_q;
    logic [1:0]        gnt;
    logic              run;
    logic              acc;
    req_t              r0, r1, sel;

    logic [ADDR_W-1:0] wa_q, ra_q;
    logic [DATA_W-1:0] wd_q;
    logic              wen_q;
    // stage 1 of the read tag: read issued to RAM this cycle, and its source
    logic              rd_v1, rd_src1;
    // stage 2: the registered return strobes
    logic              vld0_q, vld1_q;

    // Gate with reset so no accept strobe escapes while held in reset.
    assign run = (state == RUN) & Rst_n;

    rr_arb2 u_arb (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .en    (run),
        .req   ({io.Req1, io.Req0}),
        .gnt   (gnt)
    );

    assign r0  = '{we: io.We0, addr: io.Addr0, wd: io.WD0};
    assign r1  = '{we: io.We1, addr: io.Addr1, wd: io.WD1};
    assign sel = gnt[1] ? r1 : r0;
    assign acc = |gnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= RST_STATE;
            busy_q  <= RST_BUSY;
            wen_q   <= RST_BUSY;
            wa_q    <= '0;
            wd_q    <= '0;
            ra_q    <= '0;
            rd_v1   <= 1'b0;
            rd_src1 <= 1'b0;
            vld0_q  <= 1'b0;
            vld1_q  <= 1'b0;
        end else begin
            vld0_q <= rd_v1 & ~rd_src1;
            vld1_q <= rd_v1 &  rd_src1;
            rd_v1  <= 1'b0;
            case (state)
                CLEAR: begin
                    wd_q <= '0;
                    if (wa_q == ADDR_W'(DEPTH - 1)) begin
                        state  <= RUN;
                        busy_q <= 1'b0;
                        wen_q  <= 1'b0;
                    end else begin
                        wa_q <= wa_q + 1'b1;
                    end
                end
                RUN: begin
                    wen_q <= acc & sel.we;
                    if (acc & sel.we) begin
                        wa_q <= sel.addr;
                        wd_q <= sel.wd;
                    end
                    // RA holds between reads
                    if (acc & ~sel.we) ra_q <= sel.addr;
                    rd_v1   <= acc & ~sel.we;
                    rd_src1 <= gnt[1];
                end
                default: state <= RUN;
            endcase
        end
    end

    assign io.Gnt0    = gnt[0];
    assign io.Gnt1    = gnt[1];
    assign io.RdVld0  = vld0_q;
    assign io.RdVld1  = vld1_q;
    assign io.RdData  = io.RAM_RD;
    assign io.Busy    = busy_q;
    assign io.RAM_WA  = wa_q;
    assign io.RAM_WD  = wd_q;
    assign io.RAM_WEN = wen_q;
    assign io.RAM_RA  = ra_q;

endmodule
